// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register sequencer: per-stage write enables and bubble strobes for
// load-use hazards, taken branches, I/D memory waits and HLT drain.
module pipeline_hazard_ctrl #(
    parameter int RNUM_W       = 4,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RNUM_W-1:0] id_read1_num,
    input  logic [RNUM_W-1:0] id_read2_num,
    input  logic              id_uses1,
    input  logic              id_uses2,
    input  logic              id_halt,
    input  logic              ex_memread,
    input  logic [RNUM_W-1:0] ex_dest_num,
    input  logic              mem_branch_tkn,
    input  logic              imem_ready,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    output logic              pc_we,
    output logic              pc_sel_branch,
    output logic              if_id_we,
    output logic              id_ex_we,
    output logic              ex_mem_we,
    output logic              mem_wb_we,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cycles
);

    // state  | meaning
    // RUN    | normal issue; hazard priority resolved each cycle
    // DWAIT  | data memory busy, whole pipeline frozen
    // DRAIN  | HLT past ID, fetch blocked, downstream emptying
    // HALTED | pipeline empty, everything frozen until reset
    typedef enum logic [1:0] {RUN, DWAIT, DRAIN, HALTED} state_t;

    localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    state_t        state, state_nxt;
    logic [DW-1:0] drain_cnt, drain_cnt_nxt;
    logic          dmem_wait;
    logic          load_use;

    assign dmem_wait = dmem_req & ~dmem_ready;
    assign load_use  = ex_memread && (ex_dest_num != '0) &&
                       ((id_uses1 && (id_read1_num == ex_dest_num)) ||
                        (id_uses2 && (id_read2_num == ex_dest_num)));

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        pc_we         = 1'b0;
        pc_sel_branch = 1'b0;
        if_id_we      = 1'b0;
        id_ex_we      = 1'b0;
        ex_mem_we     = 1'b0;
        mem_wb_we     = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_flush  = 1'b0;
        halted        = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (dmem_wait) begin
                        state_nxt = DWAIT;
                    end else begin
                        pc_we     = 1'b1;
                        if_id_we  = 1'b1;
                        id_ex_we  = 1'b1;
                        ex_mem_we = 1'b1;
                        mem_wb_we = 1'b1;
                        if (mem_branch_tkn) begin
                            pc_sel_branch = 1'b1;
                            if_id_flush   = 1'b1;
                            id_ex_flush   = 1'b1;
                            ex_mem_flush  = 1'b1;
                        end else if (load_use) begin
                            pc_we       = 1'b0;
                            if_id_we    = 1'b0;
                            id_ex_flush = 1'b1;
                        end else if (!imem_ready) begin
                            pc_we       = 1'b0;
                            if_id_flush = 1'b1;
                        end else if (id_halt) begin
                            pc_we         = 1'b0;
                            if_id_we      = 1'b0;
                            drain_cnt_nxt = DW'(DRAIN_CYCLES);
                            state_nxt     = DRAIN;
                        end
                    end
                end
                DWAIT: begin
                    if (dmem_ready) begin
                        pc_we     = 1'b1;
                        if_id_we  = 1'b1;
                        id_ex_we  = 1'b1;
                        ex_mem_we = 1'b1;
                        mem_wb_we = 1'b1;
                        state_nxt = RUN;
                    end
                end
                DRAIN: begin
                    if (!dmem_wait) begin
                        if_id_we    = 1'b1;
                        id_ex_we    = 1'b1;
                        ex_mem_we   = 1'b1;
                        mem_wb_we   = 1'b1;
                        if_id_flush = 1'b1;
                        if (mem_branch_tkn) begin
                            // HLT was on the wrong path: redirect and resume
                            pc_we         = 1'b1;
                            pc_sel_branch = 1'b1;
                            id_ex_flush   = 1'b1;
                            ex_mem_flush  = 1'b1;
                            drain_cnt_nxt = '0;
                            state_nxt     = RUN;
                        end else if (drain_cnt <= DW'(1)) begin
                            drain_cnt_nxt = '0;
                            state_nxt     = HALTED;
                        end else begin
                            drain_cnt_nxt = drain_cnt - DW'(1);
                        end
                    end
                end
                HALTED: halted = 1'b1;
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            drain_cnt    <= '0;
            stall_cycles <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
            if ((state != HALTED) && !pc_we && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized scoreboard bench for pipeline_hazard_ctrl against a rule-level model.
module tb_pipeline_hazard_ctrl;

    localparam int RNUM_W = 4;
    localparam int DRAIN  = 3;
    localparam int CNT_W  = 4;
    localparam int SMAX   = (1 << CNT_W) - 1;

    typedef struct packed {
        logic pc_we, pc_sel, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
        logic if_id_fl, id_ex_fl, ex_mem_fl, halted;
    } outs_t;

    typedef struct packed {
        outs_t             o;
        logic [CNT_W-1:0]  s;
    } exp_t;

    localparam outs_t ALL_WE = 10'b1011110000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [RNUM_W-1:0] id_read1_num = '0, id_read2_num = '0, ex_dest_num = '0;
    logic id_uses1 = 0, id_uses2 = 0, id_halt = 0, ex_memread = 0;
    logic mem_branch_tkn = 0, imem_ready = 1, dmem_req = 0, dmem_ready = 1;
    logic pc_we, pc_sel_branch, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic if_id_flush, id_ex_flush, ex_mem_flush, halted;
    logic [CNT_W-1:0] stall_cycles;

    pipeline_hazard_ctrl #(.RNUM_W(RNUM_W), .DRAIN_CYCLES(DRAIN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_read1_num(id_read1_num), .id_read2_num(id_read2_num),
        .id_uses1(id_uses1), .id_uses2(id_uses2), .id_halt(id_halt),
        .ex_memread(ex_memread), .ex_dest_num(ex_dest_num),
        .mem_branch_tkn(mem_branch_tkn), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_we(pc_we), .pc_sel_branch(pc_sel_branch), .if_id_we(if_id_we),
        .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .halted(halted), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    exp_t expq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state
    bit m_wait, m_draining, m_halted;
    int m_left, m_stall, m_halt_age;

    task automatic cyc(input logic r, input logic [RNUM_W-1:0] a, input logic [RNUM_W-1:0] b,
                       input logic u1, input logic u2, input logic h, input logic emr,
                       input logic [RNUM_W-1:0] ed, input logic br, input logic im,
                       input logic dq, input logic dr);
        outs_t o;
        exp_t  e;
        bit    lu, active;
        @(posedge clk);
        #1;
        rst = r; id_read1_num = a; id_read2_num = b; id_uses1 = u1; id_uses2 = u2;
        id_halt = h; ex_memread = emr; ex_dest_num = ed; mem_branch_tkn = br;
        imem_ready = im; dmem_req = dq; dmem_ready = dr;
        o = '0;
        if (r) begin
            m_wait = 0; m_draining = 0; m_halted = 0; m_stall = 0; m_left = 0;
            e.s = '0;
        end else begin
            e.s    = CNT_W'(m_stall);
            active = !m_halted;
            lu = emr && (ed != 0) && ((u1 && a == ed) || (u2 && b == ed));
            if (m_halted) o.halted = 1;
            else if (m_wait) begin
                if (dr) begin o = ALL_WE; m_wait = 0; end
            end else if (dq && !dr) begin
                if (!m_draining) m_wait = 1;
            end else if (br) begin
                o = ALL_WE; o.pc_sel = 1; o.if_id_fl = 1; o.id_ex_fl = 1; o.ex_mem_fl = 1;
                m_draining = 0;
            end else if (m_draining) begin
                o = ALL_WE; o.pc_we = 0; o.if_id_fl = 1;
                m_left--;
                if (m_left <= 0) begin m_draining = 0; m_halted = 1; end
            end else if (lu) begin
                o = ALL_WE; o.pc_we = 0; o.if_id_we = 0; o.id_ex_fl = 1;
            end else if (!im) begin
                o = ALL_WE; o.pc_we = 0; o.if_id_fl = 1;
            end else if (h) begin
                o = ALL_WE; o.pc_we = 0; o.if_id_we = 0;
                m_draining = 1; m_left = DRAIN;
            end else o = ALL_WE;
            if (active && !o.pc_we && m_stall < SMAX) m_stall++;
        end
        m_halt_age = m_halted ? m_halt_age + 1 : 0;
        e.o = o;
        expq.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    endtask

    always @(negedge clk) begin
        exp_t  e;
        outs_t act;
        if (expq.size() > 0) begin
            e   = expq.pop_front();
            act = {pc_we, pc_sel_branch, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
                   if_id_flush, id_ex_flush, ex_mem_flush, halted};
            n_tests++;
            if (act !== e.o) begin
                n_fail++;
                $display("FAIL outputs t=%0t: got %b required %b", $time, act, e.o);
            end
            n_tests++;
            if (stall_cycles !== e.s) begin
                n_fail++;
                $display("FAIL stall_cycles t=%0t: got %0d required %0d", $time, stall_cycles, e.s);
            end
        end
    end

    initial begin
        logic r, h, br, im, dq, dr, u1, u2, emr;
        logic [RNUM_W-1:0] a, b, ed;
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        idle(2);
        // load-use on R3
        cyc(0, 3, 0, 1, 0, 0, 1, 3, 0, 1, 0, 1);
        idle(1);
        // load to R0 never stalls
        cyc(0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 1);
        // four-cycle data memory wait
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        // branch wins over load-use
        cyc(0, 2, 5, 0, 1, 0, 1, 5, 1, 1, 0, 1);
        // load-use together with fetch wait
        cyc(0, 4, 0, 1, 0, 0, 1, 4, 0, 0, 0, 1);
        // HLT drains then stays halted
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1);
        idle(7);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        idle(1);
        // HLT then wrong-path branch
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
        idle(5);
        // randomized traffic
        for (int i = 0; i < 5000; i++) begin
            r   = (m_halt_age > 3) || ($urandom_range(0, 199) == 0);
            a   = RNUM_W'($urandom_range(0, 3));
            b   = RNUM_W'($urandom_range(0, 3));
            ed  = RNUM_W'($urandom_range(0, 3));
            u1  = $urandom_range(0, 1) == 1;
            u2  = $urandom_range(0, 1) == 1;
            emr = $urandom_range(0, 1) == 1;
            h   = $urandom_range(0, 29) == 0;
            br  = $urandom_range(0, 14) == 0;
            im  = $urandom_range(0, 5) != 0;
            dq  = $urandom_range(0, 4) == 0;
            dr  = $urandom_range(0, 2) != 0;
            cyc(r, a, b, u1, u2, h, emr, ed, br, im, dq, dr);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries, required 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
